// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 8-bit ALU datapath.
// Owns a 4x8 register file; one command in flight at a time.
module alu_cmd_sequencer #(
  parameter int RESULT_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_ld,
  input  logic [3:0] cmd_op,
  input  logic [1:0] cmd_srca,
  input  logic [1:0] cmd_srcb,
  input  logic       cmd_imm_en,
  input  logic [7:0] cmd_imm,
  input  logic [1:0] cmd_dst,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_s,
  input  logic [7:0] alu_result,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       rsp_ready,
  output logic       busy,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [2:0] CNT_INIT = 3'(RESULT_LAT);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [3:0][7:0] regs_q, regs_d;
  logic [7:0]      alu_a_q, alu_a_d;
  logic [7:0]      alu_b_q, alu_b_d;
  logic [3:0]      alu_s_q, alu_s_d;
  logic [1:0]      dst_q, dst_d;
  logic [7:0]      rsp_q, rsp_d;
  logic            accept;
  logic            last_wait;

  assign accept    = cmd_valid & cmd_ready;
  assign last_wait = (state_q == WAIT) && (cnt_q == 3'd1);

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_s    = alu_s_q;
  assign rsp_data = rsp_q;
  assign rd_data  = regs_q[rd_sel];

  // State register; reset abandons any command in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = cmd_ld ? RESP : EXEC;
      EXEC: state_d = WAIT;
      WAIT: if (last_wait) state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs; cmd_ready is held low in reset.
  always_comb begin
    cmd_ready = reset && (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  // Datapath next state: operand capture, wait counter, write-back.
  always_comb begin
    regs_d  = regs_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_s_d = alu_s_q;
    dst_d   = dst_q;
    rsp_d   = rsp_q;
    cnt_d   = cnt_q;
    if (accept) begin
      if (cmd_ld) begin
        regs_d[cmd_dst] = cmd_imm;
        rsp_d           = cmd_imm;
      end else begin
        alu_a_d = regs_q[cmd_srca];
        alu_b_d = cmd_imm_en ? cmd_imm
                             : regs_q[cmd_srcb];
        alu_s_d = cmd_op;
        dst_d   = cmd_dst;
      end
    end
    if (state_q == EXEC) cnt_d = CNT_INIT;
    if (state_q == WAIT) cnt_d = cnt_q - 3'd1;
    if (last_wait) begin
      regs_d[dst_q] = alu_result;
      rsp_d         = alu_result;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q  <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_s_q <= '0;
      dst_q   <= '0;
      rsp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      regs_q  <= regs_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_s_q <= alu_s_d;
      dst_q   <= dst_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer.
// Bench ALU: 1-cycle registered, add when s==0 else xor.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_ld = 1'b0;
  logic [3:0] cmd_op = '0;
  logic [1:0] cmd_srca = '0;
  logic [1:0] cmd_srcb = '0;
  logic       cmd_imm_en = 1'b0;
  logic [7:0] cmd_imm = '0;
  logic [1:0] cmd_dst = '0;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_s;
  logic [7:0] alu_result = '0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ready = 1'b1;
  logic       busy;
  logic [1:0] rd_sel = '0;
  logic [7:0] rd_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] expq[$];
  logic [7:0] mon_exp;

  alu_cmd_sequencer #(.RESULT_LAT(1)) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_ld(cmd_ld),
    .cmd_op(cmd_op),
    .cmd_srca(cmd_srca),
    .cmd_srcb(cmd_srcb),
    .cmd_imm_en(cmd_imm_en),
    .cmd_imm(cmd_imm),
    .cmd_dst(cmd_dst),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_s(alu_s),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_ready(rsp_ready),
    .busy(busy),
    .rd_sel(rd_sel),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    alu_result <= (alu_s == 4'b0000)
                ? alu_a + alu_b
                : alu_a ^ alu_b;

  // Monitor: pop and compare on every response handshake.
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got 0x%0h, none expected",
                 rsp_data);
      end else begin
        mon_exp = expq.pop_front();
        if (rsp_data !== mon_exp) begin
          errors++;
          $display("FAIL rsp_data: got 0x%0h expected 0x%0h",
                   rsp_data, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after accept.
  task automatic issue(input logic       ld,
                       input logic [3:0] op,
                       input logic [1:0] sa,
                       input logic [1:0] sb,
                       input logic       ie,
                       input logic [7:0] imm,
                       input logic [1:0] dst,
                       input logic [7:0] exp,
                       input bit         push,
                       output int        acc);
    cmd_ld     = ld;
    cmd_op     = op;
    cmd_srca   = sa;
    cmd_srcb   = sb;
    cmd_imm_en = ie;
    cmd_imm    = imm;
    cmd_dst    = dst;
    cmd_valid  = 1'b1;
    if (push) expq.push_back(exp);
    acc = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got none expected accept");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy expected idle");
    end
  endtask

  task automatic check_reg(input logic [1:0] idx,
                           input logic [7:0] exp,
                           input string name);
    rd_sel = idx;
    @(negedge clk);
    chk(name, rd_data, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int rel;
    bit seen;

    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_alu_a", alu_a, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", cmd_ready, 1);
    chk("rel_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      check_reg(2'(i), 8'h00, "rst_reg");

    // Load r2 = 0x5A
    issue(1'b1, 4'h0, 2'd0, 2'd0, 1'b0, 8'h5A, 2'd2,
          8'h5A, 1'b1, acc);
    @(negedge clk);
    chk("ld_lat_valid", rsp_valid, 1);
    @(posedge clk);
    #1;
    wait_idle();
    check_reg(2'd2, 8'h5A, "ld_r2");

    // Add with wrap: r3 = 0xF0 + 0x20
    issue(1'b1, 4'h0, 2'd0, 2'd0, 1'b0, 8'hF0, 2'd0,
          8'hF0, 1'b1, acc);
    wait_idle();
    issue(1'b1, 4'h0, 2'd0, 2'd0, 1'b0, 8'h20, 2'd1,
          8'h20, 1'b1, acc);
    wait_idle();
    issue(1'b0, 4'h0, 2'd0, 2'd1, 1'b0, 8'h00, 2'd3,
          8'h10, 1'b1, acc);
    @(negedge clk);
    chk("exec_alu_a", alu_a, 8'hF0);
    chk("exec_alu_b", alu_b, 8'h20);
    chk("exec_alu_s", alu_s, 4'h0);
    chk("exec_no_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("wait_no_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("alu_lat_valid", rsp_valid, 1);
    wait_idle();
    check_reg(2'd3, 8'h10, "add_r3");

    // Immediate operand, self-destination: r0 = 0x0F ^ 0xFF
    issue(1'b1, 4'h0, 2'd0, 2'd0, 1'b0, 8'h0F, 2'd0,
          8'h0F, 1'b1, acc);
    wait_idle();
    issue(1'b0, 4'h1, 2'd0, 2'd2, 1'b1, 8'hFF, 2'd0,
          8'hF0, 1'b1, acc);
    wait_idle();
    check_reg(2'd0, 8'hF0, "imm_r0");

    // Back-pressure with a second command waiting
    rsp_ready = 1'b0;
    issue(1'b1, 4'h0, 2'd0, 2'd0, 1'b0, 8'h33, 2'd1,
          8'h33, 1'b1, acc);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_valid_seen", 32'(seen), 1);
    @(posedge clk);
    #1;
    cmd_ld     = 1'b0;
    cmd_op     = 4'h0;
    cmd_srca   = 2'd1;
    cmd_srcb   = 2'd1;
    cmd_imm_en = 1'b0;
    cmd_dst    = 2'd2;
    cmd_valid  = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 8'h33);
      chk("bp_cmd_ready", cmd_ready, 0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    rel = cyc;
    issue(1'b0, 4'h0, 2'd1, 2'd1, 1'b0, 8'h00, 2'd2,
          8'h66, 1'b1, acc);
    chk("bp_accept_delay", acc - rel, 2);
    wait_idle();
    check_reg(2'd2, 8'h66, "bp_r2");

    // Reset during WAIT; r3 holds 0x10, r0 holds 0xF0
    issue(1'b0, 4'h0, 2'd0, 2'd0, 1'b0, 8'h00, 2'd3,
          8'h00, 1'b0, acc);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    rd_sel = 2'd3;
    @(negedge clk);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_r3", rd_data, 8'h00);
    chk("mid_rst_rsp_data", rsp_data, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("post_rst_valid", rsp_valid, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_ready", cmd_ready, 1);
      @(posedge clk);
      #1;
    end
    check_reg(2'd0, 8'h00, "post_rst_r0");
    check_reg(2'd3, 8'h00, "post_rst_r3");

    // Sequencer usable after reset
    issue(1'b1, 4'h0, 2'd0, 2'd0, 1'b0, 8'hA5, 2'd1,
          8'hA5, 1'b1, acc);
    wait_idle();
    check_reg(2'd1, 8'hA5, "final_r1");

    chk("queue_empty", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-driven controller that sequences the 8-bit ALU datapath. It owns a 4-entry × 8-bit operand register file and accepts one command at a time over a valid/ready interface. For each command it drives the ALU operands and select, waits out the ALU's registered output latency, writes the result back, and returns it over a valid/ready response channel.

## Interface
- RESULT_LAT, 1: number of clock edges from ALU inputs being sampled to `alu_result` being valid. Legal range is 1..4.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_ld  in  1  1 = load `cmd_imm` into `reg[cmd_dst]` without using the ALU; 0 = ALU operation.
- cmd_op  in  4  ALU select, passed unchanged to `alu_s`.
- cmd_srca  in  2  register index for operand A.
- cmd_srcb  in  2  register index for operand B.
- cmd_imm_en  in  1  1 = operand B comes from `cmd_imm` instead of `reg[cmd_srcb]`.
- cmd_imm  in  8  immediate value.
- cmd_dst  in  2  destination register index.
- alu_a  out  8  ALU operand A (registered).
- alu_b  out  8  ALU operand B (registered).
- alu_s  out  4  ALU select (registered).
- alu_result  in  8  ALU registered output.
- rsp_valid  out  1  result available.
- rsp_data  out  8  result value written to the destination register.
- rsp_ready  in  1  consumer accepts the response.
- busy  out  1  high in every state except IDLE.
- rd_sel  in  2  debug read index.
- rd_data  out  8  `reg[rd_sel]`, combinational.

## Operation
- States are IDLE, EXEC, WAIT and RESP.
- IDLE:
  - `cmd_ready = 1`.
  - A command is accepted on a rising edge with `cmd_valid & cmd_ready`. All command fields are sampled only at that edge.
- Accept with `cmd_ld = 1`:
  - `reg[cmd_dst] <= cmd_imm` and `rsp_data <= cmd_imm` at the accept edge.
  - Next state is RESP.
  - `alu_a`, `alu_b` and `alu_s` are unchanged.
- Accept with `cmd_ld = 0`:
  - `alu_a <= reg[cmd_srca]`.
  - `alu_b <= cmd_imm_en ? cmd_imm : reg[cmd_srcb]`.
  - `alu_s <= cmd_op`.
  - The destination index is latched. Next state is EXEC.
- EXEC: lasts one cycle, during which the ALU samples its inputs. The wait counter is loaded with RESULT_LAT. Next state is WAIT.
- WAIT:
  - The counter decrements each cycle.
  - On the edge ending the cycle in which the counter equals 1: `reg[dst] <= alu_result` and `rsp_data <= alu_result`, and the next state is RESP.
- RESP:
  - `rsp_valid = 1`; `rsp_data` is held stable.
  - Leaves on the edge where `rsp_ready = 1`, going to IDLE.
  - `cmd_ready = 0` in RESP; no command overlaps a pending response.
- `alu_a`, `alu_b` and `alu_s` hold their values outside accept edges.
- The ALU is never given a new operand while a result is outstanding.
- Operand indices may equal `dst`; operands are read at accept, before write-back.
- `rd_data` reflects the register contents before the current edge; a write becomes visible the cycle after the edge.
- Arithmetic is pass-through: the sequencer does no width conversion, and results are exactly 8 bits.

## Timing
- Reset (`reset = 0`, asynchronous):
  - State goes to IDLE.
  - All four registers go to 0x00.
  - `alu_a`, `alu_b`, `rsp_data` go to 0x00; `alu_s` goes to 0x0.
  - `rsp_valid = 0`, `busy = 0`, `cmd_ready = 0` while reset is asserted.
  - `cmd_ready` goes to 1 in the first cycle after release.
- Reset asserted mid-operation: the command is abandoned, no response is produced, and registers are cleared. A write-back does not complete even if it coincides with the reset edge.
- ALU operation latency: `rsp_valid` rises (1 + RESULT_LAT) cycles after the accept edge. With RESULT_LAT = 1 this is 2 cycles.
- Load latency: `rsp_valid` rises 1 cycle after the accept edge.
- Minimum command spacing: ALU op is 3 + RESULT_LAT cycles; load is 2 cycles, when `rsp_ready` is held at 1.
- `rsp_ready` back-pressure: RESP holds indefinitely with `rsp_data` constant. `cmd_ready` remains 0 for the whole time.
- `cmd_valid` asserted while `cmd_ready = 0` is ignored. Fields may change freely until acceptance.
- `rsp_ready` asserted outside RESP has no effect.

## Test plan
The bench ALU model has a 1-cycle registered output: result = a + b (mod 256) when s = 4'b0000, otherwise a ^ b.

- **Reset values:** apply reset, then release. Required: `rd_data` = 0x00 for `rd_sel` 0..3, `cmd_ready` = 1 one cycle after release, `rsp_valid` = 0.
- **Load:** `cmd_ld` = 1, `dst` = 2, `imm` = 0x5A. Required: `rsp_valid` one cycle after accept, `rsp_data` = 0x5A, `reg2` = 0x5A.
- **ALU add with wrap:** load `r0` = 0xF0 and `r1` = 0x20, then op 0000, `srca` = 0, `srcb` = 1, `dst` = 3. Required: `alu_a` = 0xF0 and `alu_b` = 0x20 in EXEC, `rsp_valid` 2 cycles after accept, `rsp_data` = 0x10, `r3` = 0x10.
- **Immediate operand and self-destination:** `r0` = 0x0F, op 0001, `imm_en` = 1, `imm` = 0xFF, `dst` = 0. Required: `rsp_data` = 0xF0, `r0` = 0xF0.
- **Back-pressure:** hold `rsp_ready` = 0 for 5 cycles with `cmd_valid` = 1. Required: `rsp_valid` and `rsp_data` stable, `cmd_ready` = 0, and the second command is accepted only after `rsp_ready` = 1.
- **Reset mid-operation:** assert reset during WAIT. Required: no `rsp_valid`, destination = 0x00, FSM in IDLE after release.
